// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one synchronous RAM between fetch reads and load/store traffic,
// with byte-lane stores, extended loads and a streak limit so fetch is never starved forever.
localparam int cXLEN = 32;
localparam int cRamDepth = 1024;

typedef struct packed {
  logic             read;
  logic             write;
  logic [2:0]       opType;
  logic [cXLEN-1:0] addr;
  logic [cXLEN-1:0] data;
  logic [4:0]       rdAddr;
} tMemOp;

typedef struct packed {
  logic             dv;
  logic [4:0]       addr;
  logic [cXLEN-1:0] data;
} tRegOp;

module mem_port_arbiter #(
  parameter int pRamDepth = cRamDepth,
  parameter int pMaxStreak = 4,
  localparam int AW = $clog2(pRamDepth)
) (
  input  logic             iClk,
  input  logic             iRstn,
  input  logic             iFetchReq,
  input  logic [cXLEN-1:0] iFetchAddr,
  output logic             oFetchGnt,
  output logic             oFetchDv,
  output logic [cXLEN-1:0] oFetchInst,
  input  tMemOp            iMemOp,
  output logic             oMemGnt,
  output tRegOp            oLoadData,
  output logic             oMemErr,
  output logic             oRamEn,
  output logic [3:0]       oRamWe,
  output logic [AW-1:0]    oRamAddr,
  output logic [31:0]      oRamWdata,
  input  logic [31:0]      iRamRdata
);
  localparam logic [3:0] MAX = 4'(pMaxStreak);
  logic [3:0] streak_q, streak_d;
  logic tag_vld_q, tag_vld_d, tag_fetch_q, tag_fetch_d;
  logic [2:0] tag_op_q, tag_op_d;
  logic [1:0] tag_lo_q, tag_lo_d;
  logic [4:0] tag_rd_q, tag_rd_d;
  logic fetch_dv_q, fetch_dv_d, err_q, err_d;
  logic [31:0] fetch_inst_q, fetch_inst_d;
  tRegOp load_q, load_d;
  logic data_req, fetch_gnt, mem_gnt, op_bad, err, mem_ok, st_ok;
  logic [1:0] lo;
  logic [7:0] rbyte;
  logic [15:0] rhalf;
  logic [31:0] ext;
  logic unused;
  assign unused = ^{iFetchAddr[cXLEN-1:AW+2], iFetchAddr[1:0], iMemOp.addr[cXLEN-1:AW+2]};
  always_comb begin
    data_req = iMemOp.read | iMemOp.write;
    lo = iMemOp.addr[1:0];
    fetch_gnt = iRstn & iFetchReq & (!data_req | (streak_q == MAX));
    mem_gnt = iRstn & data_req & !fetch_gnt;
    op_bad = iMemOp.write ? (iMemOp.opType > 3'd2) : (iMemOp.opType inside {3'b011, 3'b110, 3'b111});
    err = (iMemOp.read & iMemOp.write) | op_bad | ((iMemOp.opType[1:0] == 2'b01) & lo[0])
        | ((iMemOp.opType[1:0] == 2'b10) & (lo != 2'b00));
    mem_ok = mem_gnt & !err;
    st_ok = mem_ok & iMemOp.write;
    oFetchGnt = fetch_gnt;
    oMemGnt = mem_gnt;
    oRamEn = fetch_gnt | mem_ok;
    oRamAddr = !oRamEn ? '0 : fetch_gnt ? iFetchAddr[AW+1:2] : iMemOp.addr[AW+1:2];
    oRamWe = !st_ok ? 4'b0000 : iMemOp.opType[1] ? 4'b1111
           : iMemOp.opType[0] ? (lo[1] ? 4'b1100 : 4'b0011) : 4'b0001 << lo;
    oRamWdata = !st_ok ? '0 : iMemOp.opType[1] ? iMemOp.data
              : iMemOp.opType[0] ? {2{iMemOp.data[15:0]}} : {4{iMemOp.data[7:0]}};
    streak_d = (!iFetchReq | fetch_gnt) ? 4'd0 : (mem_gnt & (streak_q != MAX)) ? streak_q + 4'd1 : streak_q;
    // rejected and store requests leave no tag, so they never produce a response
    tag_vld_d = fetch_gnt | (mem_ok & iMemOp.read);
    tag_fetch_d = fetch_gnt;
    tag_op_d = iMemOp.opType;
    tag_lo_d = lo;
    tag_rd_d = iMemOp.rdAddr;
    rbyte = iRamRdata[{tag_lo_q, 3'b000} +: 8];
    rhalf = tag_lo_q[1] ? iRamRdata[31:16] : iRamRdata[15:0];
    ext = tag_op_q[1] ? iRamRdata : tag_op_q[0] ? {{16{rhalf[15] & !tag_op_q[2]}}, rhalf}
        : {{24{rbyte[7] & !tag_op_q[2]}}, rbyte};
    fetch_dv_d = tag_vld_q & tag_fetch_q;
    fetch_inst_d = fetch_dv_d ? iRamRdata : fetch_inst_q;
    load_d.dv = tag_vld_q & !tag_fetch_q;
    load_d.addr = load_d.dv ? tag_rd_q : load_q.addr;
    load_d.data = load_d.dv ? ext : load_q.data;
    err_d = mem_gnt & err;
  end
  always_ff @(posedge iClk or negedge iRstn)
    if (!iRstn) begin
      streak_q <= '0;
      tag_vld_q <= 1'b0;
      tag_fetch_q <= 1'b0;
      tag_op_q <= '0;
      tag_lo_q <= '0;
      tag_rd_q <= '0;
      fetch_dv_q <= 1'b0;
      fetch_inst_q <= '0;
      load_q <= '0;
      err_q <= 1'b0;
    end else begin
      streak_q <= streak_d;
      tag_vld_q <= tag_vld_d;
      tag_fetch_q <= tag_fetch_d;
      tag_op_q <= tag_op_d;
      tag_lo_q <= tag_lo_d;
      tag_rd_q <= tag_rd_d;
      fetch_dv_q <= fetch_dv_d;
      fetch_inst_q <= fetch_inst_d;
      load_q <= load_d;
      err_q <= err_d;
    end
  assign oFetchDv = fetch_dv_q;
  assign oFetchInst = fetch_inst_q;
  assign oLoadData = load_q;
  assign oMemErr = err_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed stimulus with a byte-array reference model and literal pins.
module tb_mem_port_arbiter;
  typedef struct packed {
    logic read; logic write; logic [2:0] op; logic [31:0] addr; logic [31:0] data; logic [4:0] rd;
  } mop_t;
  typedef struct packed { logic dv; logic [4:0] addr; logic [31:0] data; } rop_t;
  typedef struct { int due; bit fetch; logic [4:0] rd; logic [31:0] val; } rsp_t;
  localparam int MAXS = 4;
  logic clk = 0, rstn = 0, freq = 0;
  logic [31:0] faddr = 0;
  mop_t mop = '0;
  logic fgnt, fdv, mgnt, merr, ren;
  logic [31:0] finst, rwdata;
  logic [31:0] rrdata = 0;
  rop_t ld;
  logic [3:0] rwe;
  logic [9:0] raddr;
  logic [31:0] ram [1024];
  logic [7:0] sh [4096];
  rsp_t q[$];
  int eq[$];
  int cyc = 0, streak = 0, checks = 0, errors = 0, ld_cnt = 0;
  int ld_cyc[$];
  logic [4:0] ld_rd[$];
  logic [31:0] last_ld = 0;
  logic m_dreq, m_fg, m_mg, m_bad, m_fdv, m_ldv, m_err;
  logic [11:0] m_a, m_wa;
  logic [31:0] m_w, m_v;
  logic [3:0] m_we;

  mem_port_arbiter #(.pRamDepth(1024), .pMaxStreak(MAXS)) dut (
    .iClk(clk), .iRstn(rstn), .iFetchReq(freq), .iFetchAddr(faddr), .oFetchGnt(fgnt),
    .oFetchDv(fdv), .oFetchInst(finst), .iMemOp(mop), .oMemGnt(mgnt), .oLoadData(ld),
    .oMemErr(merr), .oRamEn(ren), .oRamWe(rwe), .oRamAddr(raddr), .oRamWdata(rwdata),
    .iRamRdata(rrdata));

  always #5 clk = ~clk;

  always @(posedge clk) if (ren) begin
    for (int b = 0; b < 4; b++) if (rwe[b]) ram[raddr][8*b +: 8] <= rwdata[8*b +: 8];
    rrdata <= ram[raddr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge rstn) begin
    q.delete();
    eq.delete();
    streak = 0;
  end

  always @(negedge clk) begin
    if (rstn) begin
      m_fdv = q.size() > 0 && q[0].due == cyc && q[0].fetch;
      m_ldv = q.size() > 0 && q[0].due == cyc && !q[0].fetch;
      chk("fetch_dv", fdv, m_fdv);
      if (m_fdv) chk("fetch_inst", finst, q[0].val);
      chk("load_dv", ld.dv, m_ldv);
      if (m_ldv) begin
        chk("load_rd", ld.addr, q[0].rd);
        chk("load_data", ld.data, q[0].val);
      end
      if (m_fdv || m_ldv) void'(q.pop_front());
      m_err = eq.size() > 0 && eq[0] == cyc;
      chk("mem_err", merr, m_err);
      if (m_err) void'(eq.pop_front());
      if (ld.dv) begin
        ld_cnt++;
        last_ld = ld.data;
        ld_cyc.push_back(cyc);
        ld_rd.push_back(ld.addr);
      end
      m_dreq = mop.read | mop.write;
      m_fg = freq && (!m_dreq || streak >= MAXS);
      m_mg = m_dreq && !m_fg;
      chk("fetch_gnt", fgnt, m_fg);
      chk("mem_gnt", mgnt, m_mg);
      m_a = m_mg ? mop.addr[11:0] : faddr[11:0];
      m_wa = {m_a[11:2], 2'b00};
      m_bad = m_mg && ((mop.read && mop.write) || (mop.write ? mop.op > 3'd2 : mop.op inside {3'd3, 3'd6, 3'd7})
            || (mop.op % 4 == 1 && m_a % 2 != 0) || (mop.op % 4 == 2 && m_a % 4 != 0));
      chk("ram_en", ren, m_fg || (m_mg && !m_bad));
      if (m_fg || (m_mg && !m_bad)) chk("ram_addr", raddr, m_a / 4);
      m_we = 0;
      m_w = 0;
      if (m_mg && !m_bad && mop.write) begin
        if (mop.op == 0) begin
          m_we = 4'b0001 << m_a[1:0];
          m_w = {4{mop.data[7:0]}};
          sh[m_a] = mop.data[7:0];
        end else if (mop.op == 1) begin
          m_we = m_a[1] ? 4'b1100 : 4'b0011;
          m_w = {2{mop.data[15:0]}};
          sh[m_a] = mop.data[7:0];
          sh[m_a + 1] = mop.data[15:8];
        end else begin
          m_we = 4'b1111;
          m_w = mop.data;
          for (int b = 0; b < 4; b++) sh[m_wa + b] = mop.data[8*b +: 8];
        end
      end
      chk("ram_we", rwe, m_we);
      if (m_we != 0) chk("ram_wdata", rwdata, m_w);
      if (m_fg) q.push_back('{cyc + 2, 1'b1, 5'd0, {sh[m_wa + 3], sh[m_wa + 2], sh[m_wa + 1], sh[m_wa]}});
      if (m_mg && !m_bad && mop.read) begin
        case (mop.op)
          3'd0: m_v = {{24{sh[m_a][7]}}, sh[m_a]};
          3'd4: m_v = {24'd0, sh[m_a]};
          3'd1: m_v = {{16{sh[m_a + 1][7]}}, sh[m_a + 1], sh[m_a]};
          3'd5: m_v = {16'd0, sh[m_a + 1], sh[m_a]};
          default: m_v = {sh[m_wa + 3], sh[m_wa + 2], sh[m_wa + 1], sh[m_wa]};
        endcase
        q.push_back('{cyc + 2, 1'b0, mop.rd, m_v});
      end
      if (m_bad) eq.push_back(cyc + 1);
      if (!freq || m_fg) streak = 0;
      else if (m_mg) streak++;
    end
    cyc++;
  end

  task automatic xact(input logic rd, wr, input logic [2:0] op, input logic [31:0] addr, data,
                      input logic [4:0] rdd, output logic en, output logic [3:0] we, output logic [9:0] ra);
    bit got = 0;
    int i = 0;
    en = 1'bx;
    we = 'x;
    ra = 'x;
    mop = '{rd, wr, op, addr, data, rdd};
    while (!got && i < 20) begin
      @(negedge clk);
      if (mgnt) begin
        got = 1;
        en = ren;
        we = rwe;
        ra = raddr;
      end
      i++;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL gnt_timeout: no grant for addr %h", addr);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    mop = '0;
    freq = 0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bad_case(input string nm, input logic rd, wr, input logic [2:0] op, input logic [31:0] addr);
    logic en;
    logic [3:0] we;
    logic [9:0] ra;
    int n;
    n = ld_cnt;
    xact(rd, wr, op, addr, 32'hFFFF_FFFF, 5'd9, en, we, ra);
    mop = '0;
    chk({nm, "_en"}, en, 0);
    @(negedge clk);
    chk({nm, "_err"}, merr, 1);
    repeat (3) @(negedge clk);
    chk({nm, "_nodv"}, ld_cnt, n);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic fg[12], fd[12];
    logic en;
    logic [3:0] we;
    logic [9:0] ra;
    int n;
    for (int i = 0; i < 1024; i++) begin
      ram[i] = i * 32'h9E37_79B1 + 32'h1234;
      for (int b = 0; b < 4; b++) sh[4*i + b] = ram[i][8*b +: 8];
    end
    freq = 1;
    faddr = 32'h40;
    mop = '{1'b1, 1'b0, 3'd2, 32'h200, 32'd0, 5'd7};
    repeat (3) @(negedge clk);
    chk("rst_fgnt", fgnt, 0);
    chk("rst_mgnt", mgnt, 0);
    chk("rst_ctrl", {fdv, merr, ren, rwe}, 0);
    chk("rst_data", finst | rwdata | {22'd0, raddr}, 0);
    chk("rst_load", ld.data | ld.addr | ld.dv, 0);
    @(posedge clk);
    #1 rstn = 1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      fg[i] = fgnt;
      fd[i] = fdv;
      if (i == 0) chk("first_gnt_data", mgnt, 1);
    end
    for (int i = 0; i < 10; i++) chk($sformatf("pattern_%0d", i), fg[i], i % 5 == 4);
    for (int i = 2; i < 12; i++) chk($sformatf("fetch_lat_%0d", i), fd[i], fg[i-2]);
    @(posedge clk);
    #1;
    idle(3);
    xact(0, 1, 3'd2, 32'h100, 32'hDEAD_BEEF, 5'd0, en, we, ra);
    xact(0, 1, 3'd0, 32'h102, 32'h0000_005A, 5'd0, en, we, ra);
    chk("sb_we", we, 4'b0100);
    xact(1, 0, 3'd2, 32'h100, 32'd0, 5'd1, en, we, ra);
    idle(3);
    chk("lw_val", last_ld, 32'hDE5A_BEEF);
    xact(1, 0, 3'd0, 32'h102, 32'd0, 5'd2, en, we, ra);
    idle(3);
    chk("lb_val", last_ld, 32'h0000_005A);
    xact(1, 0, 3'd1, 32'h102, 32'd0, 5'd3, en, we, ra);
    idle(3);
    chk("lh_val", last_ld, 32'hFFFF_DE5A);
    xact(1, 0, 3'd5, 32'h102, 32'd0, 5'd4, en, we, ra);
    idle(3);
    chk("lhu_val", last_ld, 32'h0000_DE5A);
    bad_case("lh_mis", 1, 0, 3'd1, 32'h101);
    bad_case("sw_mis", 0, 1, 3'd2, 32'h102);
    bad_case("st_op3", 0, 1, 3'd3, 32'h100);
    xact(0, 1, 3'd2, 32'h0, 32'h1234_5678, 5'd0, en, we, ra);
    xact(1, 0, 3'd2, 32'h1000, 32'd0, 5'd3, en, we, ra);
    chk("wrap_addr", ra, 0);
    idle(3);
    chk("wrap_val", last_ld, 32'h1234_5678);
    n = ld_cyc.size();
    for (int k = 0; k < 4; k++) xact(1, 0, 3'd2, 32'h100 + 4*k, 32'd0, 5'(k + 1), en, we, ra);
    idle(4);
    if (ld_cyc.size() < n + 4) begin
      checks++;
      errors++;
      $display("FAIL b2b_count: got %0d responses expected 4", ld_cyc.size() - n);
    end else begin
      for (int k = 0; k < 4; k++) chk($sformatf("b2b_rd_%0d", k), ld_rd[n+k], k + 1);
      for (int k = 1; k < 4; k++) chk($sformatf("b2b_gap_%0d", k), ld_cyc[n+k] - ld_cyc[n+k-1], 1);
    end
    n = ld_cnt;
    xact(1, 0, 3'd2, 32'h100, 32'd0, 5'd5, en, we, ra);
    mop = '0;
    rstn = 0;
    #2 rstn = 1;
    idle(4);
    chk("midrst_nodv", ld_cnt, n);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates the core's single-ported synchronous data/instruction RAM between the fetch stage (instruction reads) and the memory stage (`tMemOp` loads/stores from the ALU output).
- Data requests have priority; a streak counter bounds fetch starvation.
- The block performs byte-lane masking for stores and sign/zero extension for loads.
- It returns load results as a `tRegOp` for writeback and fetched words to the fetch stage.

## Interface

- `pRamDepth`, default `cRamDepth` (1024): RAM depth in 32-bit words; `AW = $clog2(pRamDepth)`.
- `pMaxStreak`, default 4: maximum consecutive data grants while a fetch request is pending, from 1 to 15.

Ports:
- `iClk`  in  1  single clock, rising edge.
- `iRstn`  in  1  reset, asynchronous, active-low.
- `iFetchReq`  in  1  fetch read request, held until granted.
- `iFetchAddr`  in  cXLEN  byte address; bits [1:0] are ignored.
- `oFetchGnt`  out  1  fetch request accepted this cycle (combinational).
- `oFetchDv`  out  1  `oFetchInst` valid, one-cycle pulse.
- `oFetchInst`  out  cXLEN  fetched word.
- `iMemOp`  in  `tMemOp`  data request; active when `read` or `write` is set; held until granted.
- `oMemGnt`  out  1  data request accepted this cycle (combinational).
- `oLoadData`  out  `tRegOp`  load result: `dv` pulse, `addr` = `rdAddr`, `data` = extended value.
- `oMemErr`  out  1  rejected data request, one-cycle pulse.
- `oRamEn`  out  1  RAM access strobe.
- `oRamWe`  out  4  byte write enables; bit i covers bits [8i+7:8i].
- `oRamAddr`  out  AW  word address.
- `oRamWdata`  out  32  write data.
- `iRamRdata`  in  32  RAM read data, valid the cycle after a read strobe.

## Operation

**Arbitration** is evaluated every cycle. Requests:
- A data request exists when `iMemOp.read | iMemOp.write`.
- A fetch request exists when `iFetchReq` is high.

Grant rules:
- Only data requesting: data is granted.
- Only fetch requesting: fetch is granted.
- Both requesting: data is granted unless `streak == pMaxStreak`, in which case fetch is granted.

Streak counter (4 bits, reset 0):
- Increments on a data grant while fetch is requesting and not granted.
- Clears on a fetch grant or whenever `iFetchReq` is low.
- Saturates at `pMaxStreak`.

**RAM command** is driven combinationally in the grant cycle and sampled by the RAM at the following edge.
- `oRamAddr` = `addr[AW+1:2]`. Upper address bits are ignored, so addresses wrap modulo the RAM size.
- Fetch grant: `oRamEn=1`, `oRamWe=0`.
- Store, by `opType`:
  - `000` SB: `oRamWe = 1<<addr[1:0]`, `oRamWdata` = byte replicated ×4.
  - `001` SH: `oRamWe = 0011` or `1100` selected by `addr[1]`, `oRamWdata` = halfword replicated ×2.
  - `010` SW: `oRamWe = 1111`.
- Load: `oRamEn=1`, `oRamWe=0`.

**Error check** on data requests:
- A request is rejected when any of these hold:
  - `read & write` both set;
  - `opType` is illegal for the operation (store: not `000`/`001`/`010`; load: `011`, `110`, `111`);
  - the halfword access has `addr[0]=1`;
  - the word access has `addr[1:0]≠0`.
- A rejected request is still granted (consumed), but `oRamEn=0`, no response is produced, and `oMemErr` pulses.

**Response pipeline**:
- A one-entry tag register captures each granted read: owner (fetch/data), `opType`, `addr[1:0]`, `rdAddr`.
- The cycle after the grant, `iRamRdata` is processed and registered into the outputs:
  - Fetch: the raw word goes to `oFetchInst`.
  - LB/LBU: select the byte by `addr[1:0]`, then sign- or zero-extend to 32 bits.
  - LH/LHU: select the halfword by `addr[1]`, then sign- or zero-extend.
  - LW: the raw word.
- Stores produce no response.
- One grant per cycle, fully pipelined: back-to-back grants give back-to-back responses.

## Timing

- Grant in cycle N; RAM samples at the end of N; `iRamRdata` is valid in N+1.
- `oFetchDv`/`oLoadData.dv` assert in cycle N+2 for exactly one cycle. Load-use latency is 2.
- `oMemErr` asserts in N+1 for one cycle.
- A store in N followed by a load to the same word in N+1 returns the new data; RAM write-first is not required because the read occurs in a later cycle.

Reset values, all asynchronous on `iRstn=0`:
- Zero: `oFetchDv`, `oFetchInst`, `oLoadData` (all fields), `oMemErr`, streak, tag valid.
- `oRamEn`, `oRamWe`, `oFetchGnt` and `oMemGnt` are 0 while reset is held.
- Reset mid-transaction discards the in-flight response; no `dv` is issued after release.

## Test plan

- **Reset**: assert `iRstn=0` with both requests active. All outputs must be 0. After release, a data grant must occur in the first cycle.
- **Priority and starvation** (`pMaxStreak=4`): hold both requests continuously.
  - Grants must follow the pattern D,D,D,D,F,D,D,D,D,F….
  - Each `oFetchDv` arrives exactly 2 cycles after its `oFetchGnt`.
- **Store/load lanes**:
  - SW 0xDEADBEEF to 0x100, then SB 0x5A to 0x102. Expect `oRamWe=0100` on the SB.
  - LW from 0x100 must return 0xDE5ABEEF.
  - LB from 0x102 must return 0x0000005A.
  - LH from 0x102 must return 0xFFFFDE5A.
  - LHU from 0x102 must return 0x0000DE5A.
- **Misalign/illegal**:
  - LH at 0x101: `oMemErr` pulses in N+1, `oRamEn=0`, and no `oLoadData.dv` is produced.
  - SW at 0x102: same result.
  - Store with `opType=011`: same result.
- **Wrap and back-to-back**:
  - LW at address 0x1000 (`pRamDepth=1024`) must access word 0.
  - Four consecutive loads must give four consecutive `dv` pulses carrying the correct `rdAddr` values.
